mult_shift_add: RTL and testbench
=================================

Name: mult_shift_add

Overview:
Parametrised sequential shift-add multiplier; next generation of the fixed 4-bit unsigned multiplier.
- WIDTH-bit operands, 2*WIDTH-bit product, one multiplier bit retired per clock.
- Adds a start/busy/done handshake and a held result register.
- Sits between the operand switches/registers and the BCD conversion / seven-segment display path.

Parameters:
WIDTH, 4, operand width in bits (legal 2..32); product width is 2*WIDTH.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request; sampled on rising clk edge.
a  input  WIDTH  multiplicand, captured when start is accepted.
b  input  WIDTH  multiplier, captured when start is accepted.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when z becomes valid.
z  output  2*WIDTH  product; held until the next accepted start.
is_signed  input  1  present only with SIGNED_MODE_EN; captured with a and b.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, z=0, internal accumulator/counter=0. Takes effect immediately, including mid-operation; the partial result is discarded. No done pulse follows reset release.
- States:
  - IDLE: busy=0. If start=1 at edge k: capture a to mcand, b to mplier; acc=0; cnt=0; go to RUN.
  - RUN: busy=1, one iteration per edge.
    - If mplier[0]=1, upper half gets acc_hi + mcand as a (WIDTH+1)-bit sum; the carry is kept.
    - {carry, acc, mplier} shifts right by 1; cnt increments.
    - When cnt reaches WIDTH, go to DONE.
  - DONE: one cycle. z <= final {acc_hi, acc_lo}, done=1, busy=0, then go to IDLE.
- Latency: start accepted at edge k -> RUN for edges k+1..k+WIDTH -> z valid and done=1 after edge k+WIDTH+1. Total WIDTH+1 cycles start-to-done.
- start while busy=1: ignored; the operation in flight is unaffected. start held high through DONE is not accepted until IDLE, so back-to-back throughput is one result per WIDTH+2 cycles.
- a and b may change freely after acceptance; z is unaffected.
- z changes only on the DONE transition or reset. z is never an intermediate value.
- No overflow is possible: max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Operand 0: the full WIDTH iterations still run; there is no early termination. Result is 0.

Optional Feature:
Macro: MULT_SIGNED_MODE_EN.
- Defined:
  - is_signed port exists.
  - If captured is_signed=1, operands are two's complement. Magnitudes are multiplied unsigned; the product is negated if the operand signs differ. The sign fix-up happens in the DONE cycle, so latency is unchanged.
  - The most negative value (-2^(WIDTH-1)) is handled: (-8)*(-8)=+64 at WIDTH=4.
  - is_signed=0 behaves exactly as unsigned.
- Undefined: no is_signed port; unsigned only; logic identical to is_signed=0.

Test Plan:
- WIDTH=4, start pulse with a=4, b=5 -> busy high 4 cycles, done pulse 5 cycles after start edge, z=8'd20. Then a=0, b=0 -> z=0. Then a=15, b=15 -> z=8'd225.
- WIDTH=4, a=2, b=10 and a=10, b=2 back-to-back, start held high -> two done pulses 6 cycles apart, both z=20. Changing a/b during RUN leaves z correct.
- WIDTH=8, a=255, b=255 -> z=16'd65025 after 9 cycles. a=1, b=200 -> z=200.
- WIDTH=4, a=3, b=1 started; second start with a=14, b=1 while busy -> ignored, z=3, only one done.
- reset driven low at RUN cycle 2 of a=15, b=15 -> busy=0, z=0 immediately, no done. New start a=4, b=2 after release -> z=8.
- MULT_SIGNED_MODE_EN, WIDTH=4, is_signed=1:
  - a=4'b1101 (-3), b=5 -> z=8'hF1 (-15).
  - a=b=4'b1000 -> z=8'h40.
  - Same a=4'b1101, b=5 with is_signed=0 -> z=65.

Source files
------------

// File: rtl/mult_shift_add.sv
// mult_shift_add: sequential shift-add multiplier, one multiplier bit per clock, start/busy/done handshake.
// Optional MULT_SIGNED_MODE_EN adds is_signed for two's-complement operands (sign fix-up in the DONE cycle).
module mult_shift_add #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_MODE_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state;
  logic [WIDTH-1:0]   mcand, mplier, acc, mag_a, mag_b;
  logic [CNT_W-1:0]   cnt;
  logic               neg, neg_in;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
`ifdef MULT_SIGNED_MODE_EN
  // Magnitudes are multiplied unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
  assign mag_a  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign neg_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  assign mag_a  = a;
  assign mag_b  = b;
  assign neg_in = 1'b0;
`endif
  assign sum  = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
  assign prod = {acc, mplier};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      z      <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= neg_in;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          z     <= neg ? -prod : prod;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_shift_add.sv
// tb_mult_shift_add: directed scoreboard bench for mult_shift_add at WIDTH=4 and WIDTH=8.
module tb_mult_shift_add;
  logic clk = 0, reset = 0;
  logic start4 = 0, start8 = 0, sg4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] a8 = 0, b8 = 0, z4;
  logic [15:0] z8;
  logic busy4, done4, busy8, done8;
  int tests = 0, fails = 0;
  logic [63:0] sb[$];
  always #5 clk = ~clk;

  mult_shift_add #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
`ifdef MULT_SIGNED_MODE_EN
    .is_signed(sg4),
`endif
    .busy(busy4), .done(done4), .z(z4));

  mult_shift_add #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
`ifdef MULT_SIGNED_MODE_EN
    .is_signed(1'b0),
`endif
    .busy(busy8), .done(done8), .z(z8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pop();
    return sb.size() ? sb.pop_front() : 64'hdead_beef_dead_beef;
  endfunction

  // Called at the negedge after the accepting edge; returns negedges until done (0 = that negedge).
  task automatic wait4(output int cyc, output int bc);
    cyc = 0;
    bc = int'(busy4);
    while (!done4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      bc += int'(busy4);
    end
  endtask

  task automatic op4(input string tag, input logic [3:0] x, input logic [3:0] y, input logic s, input logic [7:0] e);
    int cyc, bc;
    a4 = x; b4 = y; start4 = 1;
`ifdef MULT_SIGNED_MODE_EN
    sg4 = s;
`else
    sg4 = s & 1'b0;
`endif
    sb.push_back(64'(e));
    @(negedge clk);
    start4 = 0;
    a4 = ~x; b4 = ~y;
    wait4(cyc, bc);
    chk({tag, "_lat"}, 64'(cyc), 64'd5);
    chk({tag, "_busy"}, 64'(bc), 64'd4);
    chk({tag, "_z"}, 64'(z4), pop());
    @(negedge clk);
    chk({tag, "_pulse"}, {63'd0, done4}, 64'd0);
  endtask

  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    int cyc;
    a8 = x; b8 = y; start8 = 1;
    sb.push_back(64'(e));
    @(negedge clk);
    start8 = 0;
    cyc = 0;
    while (!done8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd9);
    chk({tag, "_z"}, 64'(z8), pop());
  endtask

  initial begin
    int cyc, bc, nd;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", {63'd0, busy4}, 64'd0);
    chk("rst_done", {63'd0, done4}, 64'd0);
    chk("rst_z", 64'(z4), 64'd0);
    reset = 1;
    @(negedge clk);
    op4("u4x5", 4, 5, 0, 8'd20);
    op4("u0x0", 0, 0, 0, 8'd0);
    op4("u15x15", 15, 15, 0, 8'd225);
    // Back-to-back with start held; operands change during RUN.
    a4 = 2; b4 = 10; start4 = 1;
    sb.push_back(64'd20); sb.push_back(64'd20);
    @(negedge clk);
    a4 = 10; b4 = 2;
    wait4(cyc, bc);
    chk("b2b_lat1", 64'(cyc), 64'd5);
    chk("b2b_z1", 64'(z4), pop());
    @(negedge clk);
    start4 = 0; a4 = 7; b4 = 7;
    wait4(cyc, bc);
    chk("b2b_gap", 64'(cyc + 1), 64'd6);
    chk("b2b_z2", 64'(z4), pop());
    // Start while busy must be ignored.
    a4 = 3; b4 = 1; start4 = 1;
    sb.push_back(64'd3);
    @(negedge clk);
    start4 = 0;
    @(negedge clk);
    a4 = 14; b4 = 1; start4 = 1;
    @(negedge clk);
    start4 = 0;
    cyc = 0;
    while (!done4 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ign_z", 64'(z4), pop());
    nd = 0;
    repeat (10) begin @(negedge clk); nd += int'(done4); end
    chk("ign_one_done", 64'(nd), 64'd0);
    // Reset asserted in RUN cycle 2.
    a4 = 15; b4 = 15; start4 = 1;
    @(negedge clk);
    start4 = 0;
    @(negedge clk);
    reset = 0;
    #1;
    chk("mid_rst_busy", {63'd0, busy4}, 64'd0);
    chk("mid_rst_z", 64'(z4), 64'd0);
    chk("mid_rst_done", {63'd0, done4}, 64'd0);
    @(negedge clk);
    reset = 1;
    nd = 0;
    repeat (8) begin @(negedge clk); nd += int'(done4); end
    chk("mid_rst_nodone", 64'(nd), 64'd0);
    op4("u4x2", 4, 2, 0, 8'd8);
    op8("w8_255", 255, 255, 16'd65025);
    op8("w8_1x200", 1, 200, 16'd200);
`ifdef MULT_SIGNED_MODE_EN
    op4("s_m3x5", 4'b1101, 5, 1, 8'hF1);
    op4("s_m8xm8", 4'b1000, 4'b1000, 1, 8'h40);
    op4("s_off", 4'b1101, 5, 0, 8'd65);
`endif
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
